// File: rtl/updowncon_pkg.sv
// Shared types and defaults for the updowncon counter checkers.
package updowncon_pkg;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        INIT,
        SYNC,
        TRACK
    } mon_state_t;

    typedef enum logic [1:0] {
        UP,
        DN,
        HOLD,
        BAD
    } step_cls_t;

endpackage

// File: rtl/updowncon_step_cls.sv
// Classifies one observed counter step (prev -> number) modulo 2^WIDTH and
// flags steps that legally cross the 0/max boundary.
module updowncon_step_cls
    import updowncon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] number,
    output step_cls_t        cls,
    output logic             wrap
);

    logic [WIDTH-1:0] delta;

    always_comb begin
        delta = number - prev;
        cls   = BAD;
        wrap  = 1'b0;
        if (delta == WIDTH'(1)) begin
            cls  = UP;
            wrap = (number == '0);
        end else if (delta == '1) begin
            cls  = DN;
            wrap = (number == '1);
        end else if (delta == '0) begin
            cls = HOLD;
        end
    end

endmodule

// File: rtl/updowncon_mon.sv
// Passive monitor for the updowncon output bus: recovers counting direction,
// flags reversals and wraps, and counts protocol error cycles.
module updowncon_mon
    import updowncon_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     number,
    input  logic                 zero,
    input  logic                 clr,
    output logic                 dir,
    output logic                 dir_valid,
    output logic                 dir_change,
    output logic                 wrap,
    output logic                 step_err,
    output logic                 zero_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    mon_state_t           state_q, state_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic                 dir_d, dir_change_d, wrap_d, step_err_d, zero_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_d;
    step_cls_t            cls;
    logic                 cls_wrap;

    updowncon_step_cls #(.WIDTH(WIDTH)) u_step_cls (
        .prev   (prev_q),
        .number (number),
        .cls    (cls),
        .wrap   (cls_wrap)
    );

    // Direction is only trusted while tracking; SYNC means it must be relearned.
    assign dir_valid = (state_q == TRACK);

    always_comb begin
        state_d      = state_q;
        prev_d       = number;
        dir_d        = dir;
        dir_change_d = 1'b0;
        wrap_d       = 1'b0;
        step_err_d   = 1'b0;
        zero_err_d   = (zero != (number == '0));
        err_cnt_d    = err_cnt;

        case (state_q)
            INIT: begin
                state_d = SYNC;
            end
            SYNC: begin
                case (cls)
                    UP, DN: begin
                        dir_d   = (cls == UP);
                        wrap_d  = cls_wrap;
                        state_d = TRACK;
                    end
                    BAD:     step_err_d = 1'b1;
                    default: ;
                endcase
            end
            TRACK: begin
                case (cls)
                    UP, DN: begin
                        dir_change_d = ((cls == UP) != dir);
                        dir_d        = (cls == UP);
                        wrap_d       = cls_wrap;
                    end
                    default: begin
                        step_err_d = 1'b1;
                        state_d    = SYNC;
                    end
                endcase
            end
            default: state_d = INIT;
        endcase

        // One count per error cycle, however many error kinds fired in it.
        if ((step_err_d || zero_err_d) && (err_cnt != '1)) begin
            err_cnt_d = err_cnt + ERR_CNT_W'(1);
        end

        if (clr) begin
            state_d      = INIT;
            prev_d       = '0;
            dir_d        = 1'b0;
            dir_change_d = 1'b0;
            wrap_d       = 1'b0;
            step_err_d   = 1'b0;
            zero_err_d   = 1'b0;
            err_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            prev_q     <= '0;
            dir        <= 1'b0;
            dir_change <= 1'b0;
            wrap       <= 1'b0;
            step_err   <= 1'b0;
            zero_err   <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            dir        <= dir_d;
            dir_change <= dir_change_d;
            wrap       <= wrap_d;
            step_err   <= step_err_d;
            zero_err   <= zero_err_d;
            err_cnt    <= err_cnt_d;
        end
    end

endmodule

// File: doc/updowncon_mon.md
# updowncon_mon

Passive checker and direction recovery monitor for the `updowncon` up/down counter output bus. It samples `number`/`zero` every clock and classifies each step as +1, -1 or illegal. From that it recovers the counting direction, flags direction reversals and wrap-arounds, and counts protocol errors. It sits beside the counter in the 02.Counter designs and benches, is driven from the same clock and reset, and never drives the counter.

## Interface
- `WIDTH`, 4: width of the observed count bus.
- `ERR_CNT_W`, 8: width of the saturating error counter.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `number`  in  WIDTH  observed counter value.
- `zero`  in  1  observed zero flag (must equal `number==0`).
- `clr`  in  1  synchronous clear: same effect as reset, but takes effect on the clock edge.
- `dir`  out  1  recovered direction: 1 = up, 0 = down; valid only when `dir_valid`=1.
- `dir_valid`  out  1  direction has been established.
- `dir_change`  out  1  one-cycle pulse on a direction reversal.
- `wrap`  out  1  one-cycle pulse on a legal wrap: max→0 going up, 0→max going down.
- `step_err`  out  1  one-cycle pulse on an illegal step.
- `zero_err`  out  1  one-cycle pulse when `zero` ≠ (`number`==0).
- `err_cnt`  out  ERR_CNT_W  count of error cycles, saturating.

## Operation
- Registers: `prev` (WIDTH), state, `dir`, `err_cnt`.
- States:
  - `INIT`: no previous sample.
  - `SYNC`: `prev` is valid, direction unknown.
  - `TRACK`: direction known.
- Step classification (mod 2^WIDTH): `delta = number - prev`. Class is `UP` if delta=1, `DN` if delta=all-ones, `HOLD` if delta=0, otherwise `BAD`.
- Per-state behaviour:
  - `INIT`: load `prev`←`number`, go to `SYNC`. No step checks in this cycle.
  - `SYNC`:
    - `UP`/`DN`: set `dir`, set `dir_valid`=1, go to `TRACK`.
    - `HOLD`: stay in `SYNC`.
    - `BAD`: pulse `step_err`, stay in `SYNC`.
  - `TRACK`:
    - `UP`/`DN` in the same direction: no pulse.
    - `UP`/`DN` in the opposite direction: flip `dir`, pulse `dir_change`.
    - `HOLD` or `BAD`: pulse `step_err`, clear `dir_valid`, go to `SYNC` (resynchronise).
- `prev`←`number` on every non-reset cycle, in all states.
- `wrap` pulses only on a legal `UP`/`DN` step that crosses the 0/max boundary, in `SYNC` or `TRACK`.
- `zero_err` is checked in every state, including `INIT`. It is independent of `step_err`.
- `err_cnt` increments by 1 per cycle in which `step_err` or `zero_err` is high. A cycle with both still adds only 1. The counter holds at 2^ERR_CNT_W-1.
- Reset or `clr`: state=`INIT`, `prev`=0, `dir`=0, `dir_valid`=0, all pulses 0, `err_cnt`=0. `clr` has priority over all other updates.

## Timing
- All outputs are registered. A pulse appears in the cycle after the edge at which the triggering sample was taken, and lasts exactly one cycle.
- First possible classification: second sample after reset release. `dir_valid` rises one cycle after that.
- Reset mid-run clears all state immediately (asynchronous). The first sample after release is treated as `INIT`, with no spurious `step_err`.
- Simultaneous reversal and wrap (e.g. up to max, then down): not possible in a single step. A reversal step back across 0 (0→max after up-counting into 0) pulses both `dir_change` and `wrap`.

## Structure
- Package `updowncon_pkg` holds:
  - the state enum (`INIT`, `SYNC`, `TRACK`);
  - the step-class enum (`UP`, `DN`, `HOLD`, `BAD`);
  - shared localparams for `WIDTH` defaults.
- Sub-module `updowncon_step_cls`: combinational, (`prev`, `number`) → step class plus a wrap flag. It is reused by other counter checkers.
- The top level holds the FSM, registers and error counter.

## Test plan
- Reset, then `number` = 0,15,14,13 (down count) with correct `zero` → `dir_valid`=1 with `dir`=0 after the second sample. `wrap` pulses once on the 0→15 step. `err_cnt`=0.
- Up count 13,14,15,0,1 → `dir`=1, one `wrap` pulse on the 15→0 step, no errors.
- Down count 9,8,7, then switch to up 8,9 → exactly one `dir_change` pulse (on the 7→8 step), `dir`=1, `dir_valid` stays 1.
- While tracking, jump 5→9 → `step_err` pulses once, `dir_valid` drops. It is restored after the next legal step (9→10). `err_cnt`=1.
- `number`=3 with `zero`=1, and `number`=0 with `zero`=0 → one `zero_err` pulse each, `err_cnt`=2. Force 300 bad steps with `ERR_CNT_W`=8 → `err_cnt` saturates at 255.
- Assert `rst_n`=0 mid-count, release, apply 4,4,5 → no `step_err` on the first sample. `HOLD` in `SYNC` is silent. `dir`=1 after the 4→5 step.
